combo_lock_seq: RTL and testbench
=================================

Name: combo_lock_seq

Overview:
- Clocked, parametrised successor to the team's single-code combination lock FSM.
- Accepts a stream of SYM_W-bit symbols and compares each CODE_LEN-symbol attempt against a stored, reprogrammable code.
- Adds failure counting with timed lockout, timed auto-relock, and in-field code programming.
- Sits behind the keypad/debounce front end and drives the actuator enable (unlocked).

Parameters:
- CODE_LEN, 5, symbols per code (>=2).
- SYM_W, 1, bits per symbol.
- DEFAULT_CODE, 5'b11010, reset code; code[i] = bits [i*SYM_W +: SYM_W]; code[0] is entered first (default is sequence 0,1,0,1,1).
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYC, 16, lockout duration in clk cycles (>=1).
- UNLOCK_CYC, 8, auto-relock delay in OPEN; 0 disables auto-relock.
- TIMEOUT_CYC, 32, inter-symbol timeout (only with optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- sym_valid  in  1  one symbol offered this cycle.
- sym  in  SYM_W  symbol value, sampled when sym_valid=1.
- lock_now  in  1  force relock from OPEN/PROG.
- prog_en  in  1  request programming; honoured only in OPEN.
- unlocked  out  1  registered; 1 only in OPEN.
- lockout  out  1  registered; 1 only in LOCKOUT.
- state  out  2  current state encoding.
- pos  out  $clog2(CODE_LEN+1)  symbols accepted in the current attempt or program pass.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures.

Behaviour:
- States: ENTRY=0, OPEN=1, LOCKOUT=2, PROG=3. All outputs are registered and reflect the state with 1-cycle latency.
- Reset: state=ENTRY, pos=0, fail_cnt=0, unlocked=0, lockout=0, match flag=1, code_q=DEFAULT_CODE, all counters=0. Reset mid-operation discards any programmed code and any programming in progress.
- ENTRY, accepted symbol:
  - match_q &= (sym == code_q[pos]); pos+1.
  - On the CODE_LEN-th symbol with the full match true: next state OPEN, fail_cnt=0, pos=0.
  - Otherwise fail_cnt+1 and pos=0, match reset to 1. If the new fail_cnt == MAX_FAIL, go to LOCKOUT.
  - Attempts are non-overlapping; there is no sliding-window detection.
- LOCKOUT:
  - Counts LOCKOUT_CYC cycles, then returns to ENTRY with fail_cnt=0.
  - sym_valid, lock_now and prog_en are ignored.
- OPEN:
  - Symbols are ignored.
  - lock_now returns to ENTRY next cycle.
  - Otherwise prog_en moves to PROG with pos=0. lock_now has priority over prog_en.
  - If UNLOCK_CYC>0, auto-relock to ENTRY after UNLOCK_CYC cycles in OPEN. The timer restarts on each OPEN entry.
- PROG:
  - Each accepted symbol is written to shadow[pos]; pos+1.
  - On the CODE_LEN-th symbol: code_q <= shadow (new code, including the final symbol), then go to ENTRY.
  - lock_now aborts to ENTRY with code_q unchanged.
  - No auto-relock in PROG.
- Same-cycle events: a completing symbol is evaluated against code_q as it stood before that cycle.

Optional Feature:
- Macro: COMBO_LOCK_TIMEOUT_EN.
- Defined: in ENTRY or PROG with pos>0, TIMEOUT_CYC consecutive cycles without sym_valid discards the partial entry (pos=0, match=1).
  - In ENTRY this does not count as a failure.
  - In PROG it aborts to ENTRY with code_q unchanged.
- Undefined: a partial entry is held indefinitely; no timeout logic is instantiated.

Decomposition:
- Package combo_lock_pkg:
  - state typedef (2-bit enum ENTRY/OPEN/LOCKOUT/PROG).
  - State encoding constants.
  - Width helper for pos/fail_cnt.
- Sub-module combo_lock_timer: loadable down-counter with load/en/expired. Instantiated for lockout, auto-relock and (optional) timeout.

Test Plan:
- Default code: rst, then 0,1,0,1,1 with sym_valid → unlocked=1 on the cycle after the 5th symbol, fail_cnt=0, state=1.
- Wrong entry: 0,1,0,1,0 → fail_cnt=1, unlocked=0, pos=0. Then 0,1,0,1,1 → OPEN, fail_cnt=0.
- Lockout: 3 wrong attempts → lockout=1 for exactly 16 cycles. Correct code entered during lockout is ignored. After lockout: state=ENTRY, fail_cnt=0.
- Auto-relock / priority: in OPEN with no input → ENTRY after 8 cycles. In a second pass, lock_now and prog_en asserted together → ENTRY, not PROG.
- Programming: in OPEN, prog_en, then 1,1,0,0,1 → ENTRY.
  - Old code now fails; 1,1,0,0,1 unlocks.
  - rst then restores 0,1,0,1,1.
  - lock_now after 3 PROG symbols leaves the code unchanged.
- With COMBO_LOCK_TIMEOUT_EN: 0,1 then 32 idle cycles → pos=0, fail_cnt=0. Then 0,1,0,1,1 unlocks.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination lock sequencer.
// State encoding, the state enum and a counter-width helper used for the
// pos/fail_cnt outputs and the internal timers.
package combo_lock_pkg;

    localparam logic [1:0] ENC_ENTRY   = 2'd0;
    localparam logic [1:0] ENC_OPEN    = 2'd1;
    localparam logic [1:0] ENC_LOCKOUT = 2'd2;
    localparam logic [1:0] ENC_PROG    = 2'd3;

    typedef enum logic [1:0] {
        ST_ENTRY   = ENC_ENTRY,
        ST_OPEN    = ENC_OPEN,
        ST_LOCKOUT = ENC_LOCKOUT,
        ST_PROG    = ENC_PROG
    } state_t;

    // Bits needed to hold the values 0..n inclusive (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/combo_lock_seq_if.sv
// Symbol/control and status bundle between the keypad front end (master)
// and the combination lock sequencer (slave).
interface combo_lock_seq_if #(
    parameter int CODE_LEN = 5,
    parameter int SYM_W    = 1,
    parameter int MAX_FAIL = 3
);
    logic                              sym_valid;
    logic [SYM_W-1:0]                  sym;
    logic                              lock_now;
    logic                              prog_en;
    logic                              unlocked;
    logic                              lockout;
    logic [1:0]                        state;
    logic [$clog2(CODE_LEN+1)-1:0]     pos;
    logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt;

    modport master (
        output sym_valid, sym, lock_now, prog_en,
        input  unlocked, lockout, state, pos, fail_cnt
    );

    modport slave (
        input  sym_valid, sym, lock_now, prog_en,
        output unlocked, lockout, state, pos, fail_cnt
    );
endinterface

// File: rtl/combo_lock_timer.sv
// Loadable down-counter. load has priority over en; the count stops at zero
// and expired is high while the count is zero. Loading N-1 and leaving the
// phase on the first edge that sees expired gives a phase of exactly N cycles.
module combo_lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count_reg;

    // Count register: reload, or step down towards zero while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);
endmodule

// File: rtl/combo_lock_seq.sv
// Combination lock sequencer: compares CODE_LEN-symbol attempts against a
// reprogrammable code, counts failures with a timed lockout, relocks OPEN
// after UNLOCK_CYC cycles (0 = never) and supports in-field programming.
// Optional build macro COMBO_LOCK_TIMEOUT_EN adds an inter-symbol timeout
// (TIMEOUT_CYC idle cycles) that discards a partial entry.
module combo_lock_seq
    import combo_lock_pkg::*;
#(
    parameter int                         CODE_LEN     = 5,
    parameter int                         SYM_W        = 1,
    parameter logic [CODE_LEN*SYM_W-1:0]  DEFAULT_CODE = 5'b11010,
    parameter int                         MAX_FAIL     = 3,
    parameter int                         LOCKOUT_CYC  = 16,
    parameter int                         UNLOCK_CYC   = 8
`ifdef COMBO_LOCK_TIMEOUT_EN
    ,
    parameter int                         TIMEOUT_CYC  = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    combo_lock_seq_if.slave  bus
);
    localparam int PW = cnt_w(CODE_LEN);
    localparam int FW = cnt_w(MAX_FAIL);
    localparam int CW = CODE_LEN * SYM_W;
    localparam int LW = cnt_w(LOCKOUT_CYC);
    localparam logic [PW-1:0] LAST_POS = PW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);

    state_t           state_reg;
    logic [PW-1:0]    pos_reg;
    logic [FW-1:0]    fail_cnt_reg;
    logic             match_reg;
    logic [CW-1:0]    code_reg;
    logic [CW-1:0]    shadow_reg;
    logic [CW-1:0]    shadow_next;
    logic             unlocked_reg;
    logic             lockout_reg;

    logic [SYM_W-1:0] exp_sym;
    logic             match_now;
    logic             last_sym;
    logic [FW-1:0]    fail_inc;
    logic             lock_expired;
    logic             relock_expired;
    logic             timeout_hit;

    // Symbol expected at the current position, taken from the stored code.
    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_reg == PW'(i)) begin
                exp_sym = code_reg[i*SYM_W +: SYM_W];
            end
        end
    end

    assign match_now = match_reg && (bus.sym == exp_sym);
    assign last_sym  = (pos_reg == LAST_POS);
    assign fail_inc  = fail_cnt_reg + 1'b1;

    // Shadow code with the incoming symbol merged at the current position, so
    // the final programming symbol lands in the committed code.
    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_shadow
            assign shadow_next[gi*SYM_W +: SYM_W] =
                (pos_reg == PW'(gi)) ? bus.sym : shadow_reg[gi*SYM_W +: SYM_W];
        end
    endgenerate

    // Lockout timer: held loaded outside LOCKOUT, runs while locked out.
    combo_lock_timer #(.W(LW)) u_lockout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_reg != ST_LOCKOUT),
        .load_val (LW'(LOCKOUT_CYC - 1)),
        .en       (state_reg == ST_LOCKOUT),
        .expired  (lock_expired)
    );

    // Auto-relock timer: restarts on every OPEN entry because it is held
    // loaded whenever the lock is not open.
    generate
        if (UNLOCK_CYC > 0) begin : g_relock
            localparam int UW = cnt_w(UNLOCK_CYC);
            combo_lock_timer #(.W(UW)) u_relock_timer (
                .clk      (clk),
                .rst      (rst),
                .load     (state_reg != ST_OPEN),
                .load_val (UW'(UNLOCK_CYC - 1)),
                .en       (state_reg == ST_OPEN),
                .expired  (relock_expired)
            );
        end else begin : g_no_relock
            assign relock_expired = 1'b0;
        end
    endgenerate

`ifdef COMBO_LOCK_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYC);
    logic partial;
    logic to_expired;

    assign partial = ((state_reg == ST_ENTRY) || (state_reg == ST_PROG)) && (pos_reg != '0);

    // Inter-symbol timer: reloaded by every accepted symbol, runs while idle
    // with a partial entry pending.
    combo_lock_timer #(.W(TW)) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.sym_valid || !partial),
        .load_val (TW'(TIMEOUT_CYC - 1)),
        .en       (partial),
        .expired  (to_expired)
    );

    assign timeout_hit = partial && !bus.sym_valid && to_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // Main FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_ENTRY;
            pos_reg      <= '0;
            fail_cnt_reg <= '0;
            match_reg    <= 1'b1;
            code_reg     <= DEFAULT_CODE;
            shadow_reg   <= DEFAULT_CODE;
            unlocked_reg <= 1'b0;
            lockout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_ENTRY: begin
                    if (bus.sym_valid) begin
                        if (last_sym) begin
                            pos_reg   <= '0;
                            match_reg <= 1'b1;
                            if (match_now) begin
                                state_reg    <= ST_OPEN;
                                fail_cnt_reg <= '0;
                                unlocked_reg <= 1'b1;
                            end else begin
                                fail_cnt_reg <= fail_inc;
                                if (fail_inc == FAIL_LIM) begin
                                    state_reg   <= ST_LOCKOUT;
                                    lockout_reg <= 1'b1;
                                end
                            end
                        end else begin
                            pos_reg   <= pos_reg + 1'b1;
                            match_reg <= match_now;
                        end
                    end else if (timeout_hit) begin
                        pos_reg   <= '0;
                        match_reg <= 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (lock_expired) begin
                        state_reg    <= ST_ENTRY;
                        fail_cnt_reg <= '0;
                        lockout_reg  <= 1'b0;
                    end
                end

                ST_OPEN: begin
                    if (bus.lock_now) begin
                        state_reg    <= ST_ENTRY;
                        unlocked_reg <= 1'b0;
                    end else if (bus.prog_en) begin
                        state_reg    <= ST_PROG;
                        pos_reg      <= '0;
                        unlocked_reg <= 1'b0;
                    end else if (relock_expired) begin
                        state_reg    <= ST_ENTRY;
                        unlocked_reg <= 1'b0;
                    end
                end

                ST_PROG: begin
                    if (bus.lock_now || timeout_hit) begin
                        state_reg <= ST_ENTRY;
                        pos_reg   <= '0;
                        match_reg <= 1'b1;
                    end else if (bus.sym_valid) begin
                        shadow_reg <= shadow_next;
                        if (last_sym) begin
                            code_reg  <= shadow_next;
                            state_reg <= ST_ENTRY;
                            pos_reg   <= '0;
                            match_reg <= 1'b1;
                        end else begin
                            pos_reg <= pos_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_ENTRY;
                end
            endcase
        end
    end

    assign bus.unlocked = unlocked_reg;
    assign bus.lockout  = lockout_reg;
    assign bus.state    = state_reg;
    assign bus.pos      = pos_reg;
    assign bus.fail_cnt = fail_cnt_reg;
endmodule

// File: tb/tb_combo_lock_seq.sv
// Directed bench for combo_lock_seq: default code, wrong entry, lockout
// timing, auto-relock, lock_now/prog_en priority, programming, abort, reset
// restore and (with COMBO_LOCK_TIMEOUT_EN) the inter-symbol timeout.
module tb_combo_lock_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   err_cnt   = 0;
    int   total_cnt = 0;

    localparam logic [4:0] CODE_DEF   = 5'b11010;  // 0,1,0,1,1
    localparam logic [4:0] CODE_WRONG = 5'b01010;  // 0,1,0,1,0
    localparam logic [4:0] CODE_NEW   = 5'b10011;  // 1,1,0,0,1

    always #5 clk = ~clk;

    combo_lock_seq_if #(.CODE_LEN(5), .SYM_W(1), .MAX_FAIL(3)) bus ();

    combo_lock_seq #(
        .CODE_LEN     (5),
        .SYM_W        (1),
        .DEFAULT_CODE (5'b11010),
        .MAX_FAIL     (3),
        .LOCKOUT_CYC  (16),
        .UNLOCK_CYC   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-18s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_sym(input logic s);
        @(negedge clk);
        bus.sym_valid = 1'b1;
        bus.sym       = s;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.sym_valid = 1'b0;
            bus.lock_now  = 1'b0;
            bus.prog_en   = 1'b0;
        end
    endtask

    task automatic send_code(input logic [4:0] c);
        for (int i = 0; i < 5; i++) begin
            put_sym(c[i]);
        end
        idle(1);
    endtask

    task automatic pulse(input logic lk, input logic pg);
        @(negedge clk);
        bus.sym_valid = 1'b0;
        bus.lock_now  = lk;
        bus.prog_en   = pg;
        idle(1);
    endtask

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym       = 1'b0;
        bus.lock_now  = 1'b0;
        bus.prog_en   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state",    bus.state,    0);
        chk("rst_pos",      bus.pos,      0);
        chk("rst_fail",     bus.fail_cnt, 0);
        chk("rst_unlocked", bus.unlocked, 0);
        chk("rst_lockout",  bus.lockout,  0);

        // Default code unlocks
        send_code(CODE_DEF);
        chk("def_unlocked", bus.unlocked, 1);
        chk("def_state",    bus.state,    1);
        chk("def_fail",     bus.fail_cnt, 0);
        pulse(1'b1, 1'b0);
        chk("lock_state",    bus.state,    0);
        chk("lock_unlocked", bus.unlocked, 0);

        // Wrong entry, then correct entry with a mid-attempt pos check
        send_code(CODE_WRONG);
        chk("wrong_fail",     bus.fail_cnt, 1);
        chk("wrong_unlocked", bus.unlocked, 0);
        chk("wrong_pos",      bus.pos,      0);
        put_sym(1'b0);
        put_sym(1'b1);
        idle(1);
        chk("mid_pos", bus.pos, 2);
        put_sym(1'b0);
        put_sym(1'b1);
        put_sym(1'b1);
        idle(1);
        chk("right_state", bus.state,    1);
        chk("right_fail",  bus.fail_cnt, 0);

        // Auto-relock after 8 cycles in OPEN
        idle(7);
        chk("relock_7",     bus.state, 1);
        idle(1);
        chk("relock_8",     bus.state, 0);
        chk("relock_unl",   bus.unlocked, 0);

        // lock_now beats prog_en
        send_code(CODE_DEF);
        chk("reopen_state", bus.state, 1);
        pulse(1'b1, 1'b1);
        chk("prio_state", bus.state, 0);

        // Three failures -> 16-cycle lockout, code ignored meanwhile
        send_code(CODE_WRONG);
        send_code(CODE_WRONG);
        chk("two_fail", bus.fail_cnt, 2);
        send_code(CODE_WRONG);
        chk("lo_state",   bus.state,    2);
        chk("lo_flag",    bus.lockout,  1);
        chk("lo_fail",    bus.fail_cnt, 3);
        send_code(CODE_DEF);
        chk("lo_ignore_st",  bus.state,    2);
        chk("lo_ignore_unl", bus.unlocked, 0);
        idle(9);
        chk("lo_cycle16", bus.lockout, 1);
        idle(1);
        chk("lo_end_state", bus.state,    0);
        chk("lo_end_flag",  bus.lockout,  0);
        chk("lo_end_fail",  bus.fail_cnt, 0);

        // Programming a new code
        send_code(CODE_DEF);
        pulse(1'b0, 1'b1);
        chk("prog_state", bus.state,    3);
        chk("prog_pos",   bus.pos,      0);
        chk("prog_unl",   bus.unlocked, 0);
        send_code(CODE_NEW);
        chk("prog_done", bus.state, 0);
        send_code(CODE_DEF);
        chk("old_fail",  bus.fail_cnt, 1);
        chk("old_unl",   bus.unlocked, 0);
        send_code(CODE_NEW);
        chk("new_unl",   bus.unlocked, 1);
        chk("new_fail",  bus.fail_cnt, 0);

        // Abort programming after 3 symbols keeps the code
        pulse(1'b0, 1'b1);
        put_sym(1'b0);
        put_sym(1'b0);
        put_sym(1'b0);
        @(negedge clk);
        bus.sym_valid = 1'b0;
        bus.lock_now  = 1'b1;
        chk("abort_pos3", bus.pos, 3);
        idle(1);
        chk("abort_state", bus.state, 0);
        chk("abort_pos",   bus.pos,   0);
        send_code(CODE_NEW);
        chk("abort_keep", bus.unlocked, 1);

        // Reset restores the default code
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_state", bus.state,    0);
        chk("rst2_unl",   bus.unlocked, 0);
        send_code(CODE_NEW);
        chk("rst2_new_fail", bus.fail_cnt, 1);
        send_code(CODE_DEF);
        chk("rst2_def_unl", bus.unlocked, 1);
        pulse(1'b1, 1'b0);

`ifdef COMBO_LOCK_TIMEOUT_EN
        // Partial entry discarded after 32 idle cycles, not a failure
        put_sym(1'b0);
        put_sym(1'b1);
        idle(1);
        chk("to_pos_start", bus.pos, 2);
        idle(31);
        chk("to_pos_31", bus.pos, 2);
        idle(1);
        chk("to_pos_32",  bus.pos,      0);
        chk("to_fail",    bus.fail_cnt, 0);
        send_code(CODE_DEF);
        chk("to_unl", bus.unlocked, 1);
`else
        // Partial entry is held indefinitely
        put_sym(1'b0);
        put_sym(1'b1);
        idle(40);
        chk("hold_pos", bus.pos, 2);
        put_sym(1'b0);
        put_sym(1'b1);
        put_sym(1'b1);
        idle(1);
        chk("hold_unl", bus.unlocked, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
